// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its issue logic:
// op codes, SPECIAL-opcode funct values and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int unsigned MULT_CYC_DEFAULT = 5;
  localparam int unsigned DIV_CYC_DEFAULT  = 10;

  // Ops that launch a multi-cycle operation inside the MDU
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_decode.sv
// Combinational instruction -> MDU op decode; anything that is not an
// MDU-class SPECIAL instruction decodes to nop.
module mdu_decode
  import mdu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  op
);

  // Only opcode and funct select the op; the register fields are ignored
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    op = OP_NOP;
    if (instr[31:26] == OPC_SPECIAL) begin
      case (instr[5:0])
        FUNCT_MULT:  op = OP_MULT;
        FUNCT_MULTU: op = OP_MULTU;
        FUNCT_DIV:   op = OP_DIV;
        FUNCT_DIVU:  op = OP_DIVU;
        FUNCT_MFHI:  op = OP_MFHI;
        FUNCT_MFLO:  op = OP_MFLO;
        FUNCT_MTHI:  op = OP_MTHI;
        FUNCT_MTLO:  op = OP_MTLO;
        default:     op = OP_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU initiator: D-stage decode, D->E operand register and a shadow busy
// counter that stalls any MDU instruction while a mult/div is in flight.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  input  logic        stall_ext,
  output logic [3:0]  mdu_op_D,
  output logic [3:0]  mdu_op_E,
  output logic [31:0] mdu_a_E,
  output logic [31:0] mdu_b_E,
  output logic        stall_mdu,
  output logic        busy
);

  logic [CNT_W-1:0] cnt;
  logic             start_E;

  mdu_decode u_decode (
    .instr (instr_D),
    .op    (mdu_op_D)
  );

  assign start_E   = is_start_op(mdu_op_E);
  assign busy      = (cnt != '0);
  // The issue cycle itself also blocks, so the counter never needs to be reloaded while running
  assign stall_mdu = (mdu_op_D != OP_NOP) && (start_E || busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start_E) begin
      cnt <= is_mult_op(mdu_op_E) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Operands are held under a bubble; only the op is squashed
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_op_E <= OP_NOP;
      mdu_a_E  <= '0;
      mdu_b_E  <= '0;
    end else if (stall_mdu || stall_ext) begin
      mdu_op_E <= OP_NOP;
    end else begin
      mdu_op_E <= mdu_op_D;
      mdu_a_E  <= rs_data_D;
      mdu_b_E  <= rt_data_D;
    end
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit (MDU) interface.
- Decodes MDU-class instructions in the D stage and owns the D→E pipeline register for the MDU op code and operands.
- Keeps a shadow busy counter that mirrors the MDU's mult/div latency. From it the block generates the D-stage stall and the E-stage bubble, so a dependent MDU instruction never reaches the MDU while an operation is in flight.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu issue
- DIV_CYC, 10, busy cycles after a div/divu issue
- CNT_W, 4, countdown width; must hold DIV_CYC

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr_D  in  32  instruction in the D stage
- rs_data_D  in  32  forwarded rs value in D
- rt_data_D  in  32  forwarded rt value in D
- stall_ext  in  1  stall from other hazard sources; E receives a bubble
- mdu_op_D  out  4  decoded op of instr_D (combinational)
- mdu_op_E  out  4  registered op driven to the MDU
- mdu_a_E  out  32  registered rs operand to the MDU
- mdu_b_E  out  32  registered rt operand to the MDU
- stall_mdu  out  1  MDU hazard stall for the PC and D registers
- busy  out  1  shadow busy, high while the counter is nonzero

Behaviour:
- Op encoding, shared with the MDU: nop=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
- Decode: opcode 0 (SPECIAL) with funct 0x18/0x19/0x1A/0x1B/0x10/0x12/0x11/0x13 maps to mult/multu/div/divu/mfhi/mflo/mthi/mtlo. Every other instruction decodes to nop. The decode is combinational into mdu_op_D.
- start_E = mdu_op_E ∈ {mult, multu, div, divu}.
- Counter cnt (CNT_W bits) on each clk edge:
  - If start_E: cnt ← MULT_CYC for mult/multu, DIV_CYC for div/divu.
  - Else if cnt≠0: cnt ← cnt−1.
  - Net effect: busy is high for exactly N cycles following the issue cycle.
- stall_mdu = (mdu_op_D≠nop) && (start_E || cnt≠0). This is combinational.
- E register update each edge, priority high to low:
  1. reset: op_E←nop, a_E←0, b_E←0, cnt←0.
  2. stall_mdu or stall_ext: op_E←nop (bubble); a_E and b_E are don't-care but are held.
  3. Otherwise: op_E←mdu_op_D, a_E←rs_data_D, b_E←rt_data_D.
- Timing example: mult in E at cycle t. busy is high t+1..t+5. A D-stage MDU instruction stalls t..t+5 and enters E at t+6, the cycle HI/LO become valid.
- Non-MDU instructions in D never assert stall_mdu, even while busy.
- div/divu with rt=0 are issued normally; the timing is unchanged and the result is whatever the MDU produces.
- Simultaneous stall_ext and stall_mdu: still a single bubble and a single stall.
- Reset during a busy window clears cnt immediately. stall_mdu falls in the same cycle that reset is sampled, on the next edge.
- mfhi/mflo/mthi/mtlo arriving while cnt=0 and start_E=0 pass with zero stall.
- Reset values: mdu_op_E=0, mdu_a_E=0, mdu_b_E=0, busy=0, stall_mdu=0 whenever instr_D decodes to nop.

Decomposition:
- Shared package mdu_pkg holds:
  - the op-code constants nop..mtlo
  - the funct constants
  - the SPECIAL opcode value
  - MULT_CYC and DIV_CYC defaults
- The MDU and this block both import mdu_pkg.
- One natural sub-module, mdu_decode: combinational instr→op decode. It is reusable by the E/M hazard checks.

Test Plan:
1. Reset asserted with instr_D=mult (0x00850018) → mdu_op_E=0, busy=0. After release: op_E=1 next edge, busy high for 5 cycles, then low.
2. mult then mflo back-to-back in D → stall_mdu high for 6 cycles (issue cycle plus 5 busy); op_E=0 for 6 edges; then op_E=6 with a_E=rs value.
3. divu (rs=100, rt=7) followed by addu then mfhi → addu passes without stall; mfhi stalls until cnt=0; total busy is 10 cycles; op_E=4, a_E=100, b_E=7 on the issue edge.
4. mthi, then mtlo, then mfhi with no mult/div in flight → stall_mdu never asserts; op_E sequence is 7, 8, 5.
5. div with rt=0 → busy for exactly 10 cycles with no hang; a following mflo issues at issue+11.
6. multu issued, reset pulsed at busy cycle 3 while a mfhi waits in D → cnt=0 after that edge, stall_mdu=0, and mfhi enters E on the next non-reset edge.
